// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional PS2_HOST_TX_RESEND_EN: automatic re-send of the latched byte up to RETRIES times.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int RETRIES        = 2
) (
   input  logic       ps2_host_tx_clk,
   input  logic       ps2_host_tx_rst_n,
   input  logic [7:0] ps2_host_tx_data,
   input  logic       ps2_host_tx_valid,
   output logic       ps2_host_tx_ready,
   output logic       ps2_host_tx_busy,
   output logic       ps2_host_tx_done,
   output logic       ps2_host_tx_err,
   input  logic       ps2_host_tx_kclk_in,
   input  logic       ps2_host_tx_kdata_in,
   output logic       ps2_host_tx_kclk_oe,
   output logic       ps2_host_tx_kdata_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic             START_IN_FIRST = (INHIBIT_CYCLES == 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK
   } state_t;

   state_t            state_reg, state_next;
   logic [7:0]        data_reg, data_next;
   logic              parity_reg, parity_next;
   logic [2:0]        bit_cnt_reg, bit_cnt_next;
   logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
   logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
   logic              kclk_oe_reg, kclk_oe_next;
   logic              kdata_oe_reg, kdata_oe_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic              kclk_s1_reg, kclk_s2_reg, kclk_prev_reg;
   logic              kdata_s1_reg, kdata_s2_reg;
   logic              fall;
   logic              fail;

`ifdef PS2_HOST_TX_RESEND_EN
   localparam int RETRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRIES);
   logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;

   always_ff @(posedge ps2_host_tx_clk) begin
      if (!ps2_host_tx_rst_n) retry_cnt_reg <= '0;
      else                    retry_cnt_reg <= retry_cnt_next;
   end
`else
   // RETRIES only matters when re-send is enabled.
   if (RETRIES < 0) begin : g_retries_unused
   end
`endif

   always_ff @(posedge ps2_host_tx_clk) begin
      if (!ps2_host_tx_rst_n) begin
         kclk_s1_reg   <= 1'b1;
         kclk_s2_reg   <= 1'b1;
         kclk_prev_reg <= 1'b1;
         kdata_s1_reg  <= 1'b1;
         kdata_s2_reg  <= 1'b1;
         state_reg     <= IDLE;
         data_reg      <= '0;
         parity_reg    <= 1'b0;
         bit_cnt_reg   <= '0;
         inh_cnt_reg   <= '0;
         to_cnt_reg    <= '0;
         kclk_oe_reg   <= 1'b0;
         kdata_oe_reg  <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         kclk_s1_reg   <= ps2_host_tx_kclk_in;
         kclk_s2_reg   <= kclk_s1_reg;
         kclk_prev_reg <= kclk_s2_reg;
         kdata_s1_reg  <= ps2_host_tx_kdata_in;
         kdata_s2_reg  <= kdata_s1_reg;
         state_reg     <= state_next;
         data_reg      <= data_next;
         parity_reg    <= parity_next;
         bit_cnt_reg   <= bit_cnt_next;
         inh_cnt_reg   <= inh_cnt_next;
         to_cnt_reg    <= to_cnt_next;
         kclk_oe_reg   <= kclk_oe_next;
         kdata_oe_reg  <= kdata_oe_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   assign fall = kclk_prev_reg & ~kclk_s2_reg;

   always_comb begin
      state_next    = state_reg;
      data_next     = data_reg;
      parity_next   = parity_reg;
      bit_cnt_next  = bit_cnt_reg;
      inh_cnt_next  = inh_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      kclk_oe_next  = kclk_oe_reg;
      kdata_oe_next = kdata_oe_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;
      fail          = 1'b0;
`ifdef PS2_HOST_TX_RESEND_EN
      retry_cnt_next = retry_cnt_reg;
`endif

      case (state_reg)
         IDLE: begin
            kclk_oe_next  = 1'b0;
            kdata_oe_next = 1'b0;
            if (ps2_host_tx_valid) begin
               data_next     = ps2_host_tx_data;
               parity_next   = ~^ps2_host_tx_data;
               bit_cnt_next  = '0;
               inh_cnt_next  = '0;
               kclk_oe_next  = 1'b1;
               kdata_oe_next = START_IN_FIRST;
               state_next    = INHIBIT;
`ifdef PS2_HOST_TX_RESEND_EN
               retry_cnt_next = '0;
`endif
            end
         end
         INHIBIT: begin
            if (inh_cnt_reg == INH_LAST) begin
               kclk_oe_next  = 1'b0;
               kdata_oe_next = 1'b1;
               to_cnt_next   = '0;
               state_next    = START;
            end else begin
               inh_cnt_next  = inh_cnt_reg + 1'b1;
               // Start bit goes out on the final inhibit cycle.
               kdata_oe_next = (inh_cnt_reg == INH_PRE);
            end
         end
         START: begin
            kclk_oe_next  = 1'b0;
            kdata_oe_next = 1'b1;
            if (fall) begin
               kdata_oe_next = ~data_reg[0];
               bit_cnt_next  = '0;
               state_next    = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               if (bit_cnt_reg == 3'd7) begin
                  kdata_oe_next = ~parity_reg;
                  state_next    = PARITY;
               end else begin
                  bit_cnt_next  = bit_cnt_reg + 3'd1;
                  kdata_oe_next = ~data_reg[bit_cnt_reg + 3'd1];
               end
            end
         end
         PARITY: begin
            if (fall) begin
               kdata_oe_next = 1'b0;
               state_next    = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if (!kdata_s2_reg) state_next = ACK;
               else               fail       = 1'b1;
            end
         end
         ACK: begin
            if (kclk_s2_reg && kdata_s2_reg) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Device watchdog: any gap between falling edges longer than the limit aborts the frame.
      if (state_reg inside {START, DATA, PARITY, STOP, ACK} && !done_next) begin
         if (fall)                        to_cnt_next = '0;
         else if (to_cnt_reg == TO_LAST)  fail        = 1'b1;
         else                             to_cnt_next = to_cnt_reg + 1'b1;
      end

      if (fail) begin
         kclk_oe_next  = 1'b0;
         kdata_oe_next = 1'b0;
         err_next      = 1'b1;
         state_next    = IDLE;
`ifdef PS2_HOST_TX_RESEND_EN
         if (retry_cnt_reg < RETRY_MAX) begin
            retry_cnt_next = retry_cnt_reg + 1'b1;
            err_next       = 1'b0;
            kclk_oe_next   = 1'b1;
            kdata_oe_next  = START_IN_FIRST;
            inh_cnt_next   = '0;
            bit_cnt_next   = '0;
            state_next     = INHIBIT;
         end
`endif
      end
   end

   assign ps2_host_tx_ready    = (state_reg == IDLE);
   assign ps2_host_tx_busy     = (state_reg != IDLE);
   assign ps2_host_tx_done     = done_reg;
   assign ps2_host_tx_err      = err_reg;
   assign ps2_host_tx_kclk_oe  = kclk_oe_reg;
   assign ps2_host_tx_kdata_oe = kdata_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on wired-AND pads, per-cycle monitor and frame checks.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH = 120;
   localparam int TO  = 5000;
   localparam int RET = 2;
   localparam int H   = 30;
`ifdef PS2_HOST_TX_RESEND_EN
   localparam int NATT = RET + 1;
`else
   localparam int NATT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready, busy, done, err;
   logic       kclk_oe, kdata_oe;
   logic       kclk_in, kdata_in;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   assign kclk_in  = dev_clk & ~kclk_oe;
   assign kdata_in = dev_data & ~kdata_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .RETRIES(RET)
   ) dut (
      .ps2_host_tx_clk(clk),
      .ps2_host_tx_rst_n(rst_n),
      .ps2_host_tx_data(data),
      .ps2_host_tx_valid(valid),
      .ps2_host_tx_ready(ready),
      .ps2_host_tx_busy(busy),
      .ps2_host_tx_done(done),
      .ps2_host_tx_err(err),
      .ps2_host_tx_kclk_in(kclk_in),
      .ps2_host_tx_kdata_in(kdata_in),
      .ps2_host_tx_kclk_oe(kclk_oe),
      .ps2_host_tx_kdata_oe(kdata_oe)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   inh_periods = 0;
   int   inh_run = 0;
   logic done_d = 1'b0;
   logic err_d = 1'b0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Per-cycle monitor: handshake invariants, pulse shapes, inhibit length and start-bit timing.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         inh_run = 0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else if (mon_en) begin
         chk("ready_vs_busy", ready, !busy);
         chk("done_err_excl", done & err, 0);
         if (done | err) chk("oe_released_at_end", {kclk_oe, kdata_oe}, 0);
         if (done) begin
            chk("done_one_cycle", done_d, 0);
            done_cnt++;
         end
         if (err) begin
            chk("err_one_cycle", err_d, 0);
            err_cnt++;
         end
         if (kclk_oe) begin
            chk("inhibit_kdata", kdata_oe, (inh_run == INH - 1));
            inh_run++;
         end else if (inh_run != 0) begin
            chk("inhibit_len", inh_run, INH);
            inh_periods++;
            inh_run = 0;
         end
         done_d = done;
         err_d  = err;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b);
      int k;
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      k = 0;
      while (!ready && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (!ready) chk("accept_wait", ready, 1);
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Device side of one frame. ack_mode: 1 = ACK, 0 = NACK, 2 = stop after nfalls edges.
   task automatic device_frame(input logic [7:0] b, input int nfalls, input int ack_mode,
                               output logic [10:0] smp);
      logic [10:0] exp_bits;
      logic [10:0] got;
      int k;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
      exp_bits[9]  = ($countones(b) % 2 == 0);
      exp_bits[10] = 1'b1;
      got = '1;
      k = 0;
      while (!(kdata_oe && !kclk_oe && busy) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      if (!(kdata_oe && !kclk_oe && busy)) begin
         chk("request_to_send", kdata_oe & ~kclk_oe & busy, 1);
         smp = got;
         return;
      end
      wait_cyc(10);
      got[0] = kdata_in;
      chk("start_bit", got[0], exp_bits[0]);
      for (int f = 1; f <= nfalls && f <= 10; f++) begin
         dev_clk = 1'b0;
         wait_cyc(H);
         dev_clk = 1'b1;
         got[f] = kdata_in;
         chk($sformatf("frame_bit%0d", f), got[f], exp_bits[f]);
         wait_cyc(H);
      end
      if (ack_mode != 2) begin
         if (ack_mode == 1) dev_data = 1'b0;
         wait_cyc(H / 2);
         dev_clk = 1'b0;
         wait_cyc(H);
         dev_clk = 1'b1;
         wait_cyc(H / 2);
         dev_data = 1'b1;
      end
      smp = got;
   endtask

   initial begin
      logic [10:0] smp;
      logic [7:0]  b;
      int d0, e0, i0, k;

      rst_n = 1'b0;
      wait_cyc(4);
      chk("reset_oe_in_reset", {kclk_oe, kdata_oe}, 0);
      rst_n = 1'b1;
      wait_cyc(2);
      chk("reset_ready", ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_oe", {kclk_oe, kdata_oe}, 0);
      chk("reset_pulses", {done, err}, 0);
      mon_en = 1'b1;

      // 0xED set-LEDs, device ACKs
      d0 = done_cnt; e0 = err_cnt; i0 = inh_periods;
      send_byte(8'hED);
      device_frame(8'hED, 10, 1, smp);
      wait_cyc(20);
      chk("ed_samples", smp, 11'b111_1101_1010);
      chk("ed_done", done_cnt - d0, 1);
      chk("ed_err", err_cnt - e0, 0);
      chk("ed_inhibits", inh_periods - i0, 1);
      chk("ed_ready", ready, 1);
      $display("tx 0xED: samples=%03h done=%0d err=%0d", smp, done_cnt - d0, err_cnt - e0);

      // 0x00 then 0x01 back to back; requester holds valid with the next byte throughout
      d0 = done_cnt; e0 = err_cnt; i0 = inh_periods;
      send_byte(8'h00);
      @(negedge clk);
      data  = 8'h01;
      valid = 1'b1;
      device_frame(8'h00, 10, 1, smp);
      chk("b2b_parity0", smp[9], 1);
      k = 0;
      while (!ready && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_second_accept_wait", ready, 1);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_done_before_second", done_cnt - d0, 1);
      chk("b2b_one_inhibit_before", inh_periods - i0, 1);
      $display("tx 0x00: samples=%03h done=%0d", smp, done_cnt - d0);
      device_frame(8'h01, 10, 1, smp);
      wait_cyc(20);
      chk("b2b_parity1", smp[9], 0);
      chk("b2b_done_total", done_cnt - d0, 2);
      chk("b2b_err", err_cnt - e0, 0);
      $display("tx 0x01: samples=%03h done=%0d", smp, done_cnt - d0);

      // Silent device: timeout measured from START entry
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h5A);
      for (int a = 0; a < NATT; a++) begin
         k = 0;
         while (!(kdata_oe && !kclk_oe && busy) && k < 20000) begin
            @(negedge clk);
            k++;
         end
         k = 0;
         while (!(err || kclk_oe) && k < TO + 10) begin
            @(negedge clk);
            k++;
         end
         chk("timeout_cycles", k, TO);
         if (a == NATT - 1) chk("timeout_err", err, 1);
         else               chk("timeout_retry", {err, kclk_oe}, 2'b01);
      end
      wait_cyc(5);
      chk("timeout_err_count", err_cnt - e0, 1);
      chk("timeout_no_done", done_cnt - d0, 0);
      chk("timeout_ready", ready, 1);
      $display("tx 0x5A: timeout err=%0d done=%0d", err_cnt - e0, done_cnt - d0);

      // Device NACKs every attempt
      d0 = done_cnt; e0 = err_cnt; i0 = inh_periods;
      send_byte(8'hC3);
      for (int a = 0; a < NATT; a++) device_frame(8'hC3, 10, 0, smp);
      wait_cyc(20);
      chk("nack_err", err_cnt - e0, 1);
      chk("nack_no_done", done_cnt - d0, 0);
      chk("nack_inhibits", inh_periods - i0, NATT);
      $display("tx 0xC3: nack err=%0d done=%0d", err_cnt - e0, done_cnt - d0);

`ifdef PS2_HOST_TX_RESEND_EN
      // NACK twice, then ACK: retried transparently
      d0 = done_cnt; e0 = err_cnt; i0 = inh_periods;
      send_byte(8'hA7);
      device_frame(8'hA7, 10, 0, smp);
      device_frame(8'hA7, 10, 0, smp);
      chk("retry_busy_between", busy, 1);
      device_frame(8'hA7, 10, 1, smp);
      wait_cyc(20);
      chk("retry_inhibits", inh_periods - i0, 3);
      chk("retry_done", done_cnt - d0, 1);
      chk("retry_no_err", err_cnt - e0, 0);
      $display("tx 0xA7: retried done=%0d err=%0d", done_cnt - d0, err_cnt - e0);
`endif

      // Reset while data bit 4 is on the line
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h3C);
      device_frame(8'h3C, 5, 2, smp);
      wait_cyc(3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_oe", {kclk_oe, kdata_oe}, 0);
      chk("midreset_pulses", {done, err}, 0);
      chk("midreset_ready", ready, 1);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);
      chk("midreset_after_ready", ready, 1);
      chk("midreset_no_done", done_cnt - d0, 0);
      chk("midreset_no_err", err_cnt - e0, 0);
      $display("tx 0x3C: reset mid-frame ready=%0d", ready);
      send_byte(8'hF4);
      device_frame(8'hF4, 10, 1, smp);
      wait_cyc(20);
      chk("f4_done", done_cnt - d0, 1);
      chk("f4_err", err_cnt - e0, 0);
      $display("tx 0xF4: samples=%03h done=%0d", smp, done_cnt - d0);

      // Random command bytes with ACK
      for (int r = 0; r < 4; r++) begin
         b  = 8'($urandom_range(0, 255));
         d0 = done_cnt; e0 = err_cnt;
         send_byte(b);
         device_frame(b, 10, 1, smp);
         wait_cyc(20);
         chk("rand_done", done_cnt - d0, 1);
         chk("rand_err", err_cnt - e0, 0);
         $display("tx 0x%02h: samples=%03h done=%0d", b, smp, done_cnt - d0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter.
- Sends one command byte to the keyboard over the shared open-drain PS2_CLK/PS2_DATA lines, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside the keyboard receiver; both see the same pads. System logic ignores received bytes while ps2_host_tx_busy is high.

Parameters:
- INHIBIT_CYCLES, 12000, system clocks PS2_CLK is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, max system clocks between consecutive device falling edges, measured from inhibit release (15 ms).
- RETRIES, 2, extra attempts after a failed frame; used only with PS2_HOST_TX_RESEND_EN.

Ports:
- ps2_host_tx_clk  input  1  system clock, CLK100MHZ
- ps2_host_tx_rst_n  input  1  synchronous active-low reset
- ps2_host_tx_data  input  8  command byte
- ps2_host_tx_valid  input  1  request; byte is captured when valid && ready
- ps2_host_tx_ready  output  1  high only in IDLE
- ps2_host_tx_busy  output  1  high in every state except IDLE
- ps2_host_tx_done  output  1  one-cycle pulse: frame acknowledged
- ps2_host_tx_err  output  1  one-cycle pulse: frame failed (timeout or no ACK)
- ps2_host_tx_kclk_in  input  1  PS2_CLK pad value
- ps2_host_tx_kdata_in  input  1  PS2_DATA pad value
- ps2_host_tx_kclk_oe  output  1  1 = drive PS2_CLK low, 0 = release
- ps2_host_tx_kdata_oe  output  1  1 = drive PS2_DATA low, 0 = release

Behaviour:
- Reset is synchronous, active-low, sampled on the rising edge of ps2_host_tx_clk.
- Reset values:
  - state = IDLE
  - kclk_oe = 0, kdata_oe = 0
  - done = 0, err = 0
  - counters = 0
  - sync flops = 1
  - ready reads 1 (state-decoded), busy = 0
- Input conditioning:
  - kclk_in and kdata_in each pass through 2-flop synchronizers.
  - fall = previous synced kclk high and current synced kclk low.
  - Edge-detect latency is 3 clocks from the pad.
- Accept: when valid && ready, latch the data byte, compute parity = ~^data (odd parity), clear the bit count, and enter INHIBIT.
- INHIBIT: kclk_oe = 1 for exactly INHIBIT_CYCLES clocks. On the last of these cycles, set kdata_oe = 1 (start bit, data low). Then go to START.
- START:
  - kclk_oe = 0, kdata_oe = 1.
  - Timeout counter reloads.
  - The next fall moves to DATA with kdata_oe = ~data[0].
- DATA:
  - On each fall, shift out the next bit LSB first; kdata_oe = ~bit.
  - After bit7 has been placed, the next fall places parity (kdata_oe = ~parity) and moves to PARITY.
- PARITY: the next fall releases data (kdata_oe = 0, stop bit) and moves to STOP.
- STOP: the next fall samples synced kdata.
  - 0 -> ACK state.
  - 1 -> error.
- ACK: wait until synced kclk and kdata are both 1. Then pulse done for 1 cycle and return to IDLE.
- Timeout:
  - In START, DATA, PARITY, STOP and ACK, the counter increments each clock and clears on each fall.
  - Reaching TIMEOUT_CYCLES -> error.
- Error: release both lines the same cycle, pulse err for 1 cycle, return to IDLE.
- Arithmetic:
  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
  - Inhibit counter width is $clog2(INHIBIT_CYCLES+1).
  - Bit count is 3 bits, 0-7, no wrap beyond 7.
- valid while busy is ignored; the byte is not queued. The requester holds valid until ready.
- Device traffic already in flight at accept is aborted by the inhibit; this is legal PS/2 and no special handling is needed.
- done and err are never high in the same cycle.
- Reset mid-frame: both oe go to 0 on that clock edge. No done or err pulse is generated. The device discards the partial frame.

Optional Feature:
- PS2_HOST_TX_RESEND_EN defined:
  - On a failure, the block does not pulse err. It re-enters INHIBIT with the same latched byte, up to RETRIES times.
  - err pulses only after the final attempt fails.
  - busy stays high throughout all attempts.
  - The retry count clears on accept and on reset.
- Undefined: every failure pulses err immediately and returns to IDLE. The RETRIES parameter is unused.

Test Plan:
- Send 0xED with a device model that clocks at 12 kHz and ACKs:
  - kclk_oe high for exactly 12000 cycles.
  - Device samples 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once after lines idle; ready returns to 1.
- Send 0x00 then 0x01 back to back: parity bits are 1 and 0 respectively; the second byte is accepted only after the first done.
- Device never clocks after inhibit:
  - err pulses exactly TIMEOUT_CYCLES clocks after START entry.
  - Both oe = 0 in that cycle.
  - Use TIMEOUT_CYCLES = 5000 in sim.
- Device clocks 11 edges but holds data high at the ACK edge: err pulses, done stays 0.
- Assert reset during DATA bit 4: kclk_oe and kdata_oe are 0 the next cycle; no done or err; after release, ready = 1 and a new 0xF4 frame completes normally.
- With PS2_HOST_TX_RESEND_EN and RETRIES = 2, device NACKs twice then ACKs: three inhibit periods seen, a single done pulse, no err.
